// File: rtl/bsg_fifos_to_axil.sv
// Bridges a valid/ready request stream and a valid/yumi response stream onto an
// AXI-Lite master port, keeping exactly one transaction in flight at a time.

package bsg_axil_pkg;

    // Master-driven AXI-Lite signals; field order matches the packed bus layout.
    typedef struct packed {
        logic [31:0] awaddr;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic        arvalid;
        logic        rready;
    } bsg_axil_mosi_bus_s;

    // Slave-driven AXI-Lite signals.
    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } bsg_axil_miso_bus_s;

endpackage

module bsg_fifos_to_axil
    import bsg_axil_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_n_i,

    output bsg_axil_mosi_bus_s m_axil_bus_o,
    input  bsg_axil_miso_bus_s m_axil_bus_i,

    input  logic               req_v_i,
    input  logic               req_we_i,
    input  logic [31:0]        req_addr_i,
    input  logic [31:0]        req_data_i,
    input  logic [3:0]         req_wstrb_i,
    output logic               req_ready_o,

    output logic               resp_v_o,
    output logic               resp_we_o,
    output logic [31:0]        resp_data_o,
    output logic [1:0]         resp_code_o,
    input  logic               resp_yumi_i,

    output logic               busy_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_e;

    state_e      state_r, state_n;

    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [3:0]  wstrb_r;
    logic        we_r;
    logic        aw_done_r;
    logic        w_done_r;
    logic [31:0] resp_data_r;
    logic [1:0]  resp_code_r;

    logic        accept;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        aw_complete, w_complete;

    // Request side: ready only when idle and out of reset.
    assign req_ready_o = (state_r == IDLE) & reset_n_i;
    assign accept      = req_v_i & req_ready_o;
    assign busy_o      = (state_r != IDLE);

    // Valids and readies depend only on state and done flags, never on an AXI ready.
    assign awvalid = (state_r == WR_REQ) & ~aw_done_r;
    assign wvalid  = (state_r == WR_REQ) & ~w_done_r;
    assign bready  = (state_r == WR_RESP);
    assign arvalid = (state_r == RD_ADDR);
    assign rready  = (state_r == RD_DATA);

    assign aw_hs = awvalid & m_axil_bus_i.awready;
    assign w_hs  = wvalid  & m_axil_bus_i.wready;
    assign b_hs  = bready  & m_axil_bus_i.bvalid;
    assign ar_hs = arvalid & m_axil_bus_i.arready;
    assign r_hs  = rready  & m_axil_bus_i.rvalid;

    // The aw and w channels may complete in either order or together.
    assign aw_complete = aw_done_r | aw_hs;
    assign w_complete  = w_done_r  | w_hs;

    always_comb begin
        m_axil_bus_o         = '0;
        m_axil_bus_o.awaddr  = addr_r;
        m_axil_bus_o.awvalid = awvalid;
        m_axil_bus_o.wdata   = data_r;
        m_axil_bus_o.wstrb   = wstrb_r;
        m_axil_bus_o.wvalid  = wvalid;
        m_axil_bus_o.bready  = bready;
        m_axil_bus_o.araddr  = addr_r;
        m_axil_bus_o.arvalid = arvalid;
        m_axil_bus_o.rready  = rready;
    end

    assign resp_v_o    = (state_r == RESP);
    assign resp_we_o   = we_r;
    assign resp_data_o = resp_data_r;
    assign resp_code_o = resp_code_r;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE:    if (accept)                    state_n = req_we_i ? WR_REQ : RD_ADDR;
            WR_REQ:  if (aw_complete & w_complete)  state_n = WR_RESP;
            WR_RESP: if (b_hs)                      state_n = RESP;
            RD_ADDR: if (ar_hs)                     state_n = RD_DATA;
            RD_DATA: if (r_hs)                      state_n = RESP;
            RESP:    if (resp_yumi_i)               state_n = IDLE;
            default:                                state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_r  <= '0;
            data_r  <= '0;
            wstrb_r <= '0;
            we_r    <= 1'b0;
        end else if (accept) begin
            addr_r  <= req_addr_i;
            data_r  <= req_data_i;
            wstrb_r <= req_wstrb_i;
            we_r    <= req_we_i;
        end
    end

    // Each write channel drops its valid the cycle after its own handshake.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else if (accept) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            if (aw_hs) aw_done_r <= 1'b1;
            if (w_hs)  w_done_r  <= 1'b1;
        end
    end

    // Error codes are captured verbatim and never steer the state machine.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_data_r <= '0;
            resp_code_r <= '0;
        end else if (b_hs) begin
            resp_data_r <= '0;
            resp_code_r <= m_axil_bus_i.bresp;
        end else if (r_hs) begin
            resp_data_r <= m_axil_bus_i.rdata;
            resp_code_r <= m_axil_bus_i.rresp;
        end
    end

endmodule

// File: tb/tb_bsg_fifos_to_axil.sv
// Self-checking bench for bsg_fifos_to_axil: the bench plays the AXI-Lite slave with
// programmable channel delays and predicts every handshake and response from the protocol rules.

module tb_bsg_fifos_to_axil;
    import bsg_axil_pkg::*;

    logic               clk;
    logic               reset_n;
    bsg_axil_mosi_bus_s mosi;
    bsg_axil_miso_bus_s miso;
    logic               req_v, req_we, req_ready;
    logic [31:0]        req_addr, req_data;
    logic [3:0]         req_wstrb;
    logic               resp_v, resp_we, resp_yumi;
    logic [31:0]        resp_data;
    logic [1:0]         resp_code;
    logic               busy;

    int vectors;
    int miscompares;

    // Expected response registers after the most recent completed transaction.
    logic        last_we;
    logic [31:0] last_data;
    logic [1:0]  last_code;

    bsg_fifos_to_axil dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .m_axil_bus_o (mosi),
        .m_axil_bus_i (miso),
        .req_v_i      (req_v),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_wstrb_i  (req_wstrb),
        .req_ready_o  (req_ready),
        .resp_v_o     (resp_v),
        .resp_we_o    (resp_we),
        .resp_data_o  (resp_data),
        .resp_code_o  (resp_code),
        .resp_yumi_i  (resp_yumi),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ctl_bits();
        return {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready,
                resp_v, req_ready, busy};
    endfunction

    // One transaction against a slave whose channels become ready after the given delays.
    task automatic run_txn(input string name, input bit we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int aw_d, input int w_d, input int b_d,
                           input int ar_d, input int r_d, input int y_d,
                           input logic [1:0] code, input logic [31:0] rdata, input bit hold_v);
        bit          aw_m, w_m, b_m, ar_m, r_m, fin, resp_exp;
        int          both_c, ar_c, rc;
        logic [7:0]  ctl_exp, ctl_act;
        logic [31:0] exp_data;
        aw_m = 0; w_m = 0; b_m = 0; ar_m = 0; r_m = 0; fin = 0;
        both_c = 0; ar_c = 0; rc = 0;
        exp_data = we ? 32'h0 : rdata;

        @(negedge clk);
        vectors++;
        if ({req_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL %s idle: ready,busy=%b want 10", name, {req_ready, busy});
        end
        req_v = 1'b1; req_we = we; req_addr = addr; req_data = data; req_wstrb = strb;
        @(posedge clk);

        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            if (!hold_v) begin
                req_v = 1'b0; req_we = 1'($urandom);
                req_addr = $urandom; req_data = $urandom; req_wstrb = 4'($urandom);
            end
            resp_exp = we ? b_m : r_m;
            ctl_exp = {we & !aw_m, we & !w_m, we & aw_m & w_m & !b_m,
                       !we & !ar_m, !we & ar_m & !r_m, resp_exp, 1'b0, 1'b1};
            ctl_act = ctl_bits();
            vectors++;
            if (ctl_act !== ctl_exp) begin
                miscompares++;
                $display("FAIL %s cyc%0d ctl: got %b want %b", name, c, ctl_act, ctl_exp);
            end
            if (we && !aw_m) begin
                vectors++;
                if (mosi.awaddr !== addr) begin
                    miscompares++;
                    $display("FAIL %s cyc%0d awaddr: got %h want %h", name, c, mosi.awaddr, addr);
                end
            end
            if (we && !w_m) begin
                vectors++;
                if ({mosi.wdata, mosi.wstrb} !== {data, strb}) begin
                    miscompares++;
                    $display("FAIL %s cyc%0d wdata/wstrb: got %h/%h want %h/%h",
                             name, c, mosi.wdata, mosi.wstrb, data, strb);
                end
            end
            if (!we && !ar_m) begin
                vectors++;
                if (mosi.araddr !== addr) begin
                    miscompares++;
                    $display("FAIL %s cyc%0d araddr: got %h want %h", name, c, mosi.araddr, addr);
                end
            end
            if (resp_exp) begin
                vectors++;
                if ({resp_we, resp_data, resp_code} !== {we, exp_data, code}) begin
                    miscompares++;
                    $display("FAIL %s cyc%0d resp we/data/code: got %b/%h/%0d want %b/%h/%0d",
                             name, c, resp_we, resp_data, resp_code, we, exp_data, code);
                end
            end

            // Slave behaviour for the upcoming edge.
            miso.awready = (c >= 1 + aw_d);
            miso.wready  = (c >= 1 + w_d);
            miso.bvalid  = aw_m && w_m && (c >= both_c + b_d);
            miso.bresp   = miso.bvalid ? code : 2'($urandom);
            miso.arready = (c >= 1 + ar_d);
            miso.rvalid  = ar_m && (c >= ar_c + r_d);
            miso.rresp   = miso.rvalid ? code : 2'($urandom);
            miso.rdata   = miso.rvalid ? rdata : $urandom;
            if (resp_exp) begin
                rc++;
                resp_yumi = (rc > y_d);
            end else begin
                resp_yumi = 1'($urandom_range(0, 1));
            end

            // Handshakes that the upcoming edge completes.
            if (ctl_exp[7] && miso.awready) aw_m = 1;
            if (ctl_exp[6] && miso.wready)  w_m  = 1;
            if (we && aw_m && w_m && both_c == 0) both_c = c + 1;
            if (ctl_exp[5] && miso.bvalid)  b_m  = 1;
            if (ctl_exp[4] && miso.arready) begin
                ar_m = 1;
                ar_c = c + 1;
            end
            if (ctl_exp[3] && miso.rvalid)  r_m  = 1;
            if (resp_exp && resp_yumi)      fin  = 1;
        end
        @(posedge clk);
        #1;
        miso = '0;
        resp_yumi = 1'b0;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL %s timeout: completed=%b want 1", name, fin);
        end
        last_we = we; last_data = exp_data; last_code = code;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        vectors++;
        if ({ctl_bits(), resp_we, resp_data, resp_code} !== '0) begin
            miscompares++;
            $display("FAIL reset state: ctl=%b we=%b data=%h code=%0d want all 0",
                     ctl_bits(), resp_we, resp_data, resp_code);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        vectors++;
        if (ctl_bits() !== 8'b0000_0010) begin
            miscompares++;
            $display("FAIL reset release: ctl=%b want 00000010", ctl_bits());
        end
    endtask

    task automatic test_zero_wait_write();
        run_txn("zero_wait_write", 1'b1, 32'h0000_010C, 32'hA5A5_0001, 4'hF,
                0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_skewed_write();
        run_txn("skewed_write", 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h5,
                3, 0, 1, 0, 0, 1, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_read();
        run_txn("read", 1'b0, 32'h0000_011C, 32'h0, 4'h0,
                0, 0, 0, 2, 0, 0, 2'b00, 32'h0000_0004, 1'b0);
    endtask

    task automatic test_error_backpressure();
        run_txn("read_slverr_bp", 1'b0, 32'h0000_0300, 32'h0, 4'h0,
                0, 0, 0, 0, 1, 5, 2'b10, 32'hDEAD_BEEF, 1'b0);
        run_txn("write_decerr", 1'b1, 32'h0000_0304, 32'hCAFE_F00D, 4'h3,
                1, 2, 0, 0, 0, 2, 2'b11, 32'h0, 1'b0);
    endtask

    task automatic test_stray_input();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            miso.bvalid = 1'b1; miso.bresp = 2'b10;
            miso.rvalid = 1'b1; miso.rresp = 2'b01; miso.rdata = $urandom;
            miso.awready = 1'b1; miso.wready = 1'b1; miso.arready = 1'b1;
            resp_yumi = 1'b1;
            if (i > 0) begin
                vectors++;
                if ({ctl_bits(), resp_we, resp_data, resp_code} !==
                    {8'b0000_0010, last_we, last_data, last_code}) begin
                    miscompares++;
                    $display("FAIL stray_input %0d: ctl=%b we=%b data=%h code=%0d want 00000010/%b/%h/%0d",
                             i, ctl_bits(), resp_we, resp_data, resp_code, last_we, last_data, last_code);
                end
            end
        end
        @(negedge clk);
        miso = '0;
        resp_yumi = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        req_v = 1'b1; req_we = 1'b1; req_addr = $urandom; req_data = $urandom; req_wstrb = 4'hF;
        miso.awready = 1'b1; miso.wready = 1'b1;
        @(negedge clk);
        req_v = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl_bits() !== 8'b0010_0001) begin
            miscompares++;
            $display("FAIL reset_mid_op in WR_RESP: ctl=%b want 00100001", ctl_bits());
        end
        miso = '0;
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({ctl_bits(), resp_we, resp_data, resp_code} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_op async: ctl=%b we=%b data=%h code=%0d want all 0",
                     ctl_bits(), resp_we, resp_data, resp_code);
        end
        miso.bvalid = 1'b1; miso.bresp = 2'b01;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ctl_bits(), resp_code} !== {8'b0000_0010, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_mid_op after: ctl=%b code=%0d want 00000010/0", ctl_bits(), resp_code);
        end
        miso = '0;
        last_we = 1'b0; last_data = '0; last_code = '0;
        run_txn("post_reset_write", 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hC,
                0, 1, 2, 0, 0, 0, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first", 1'b1, 32'h0000_0500, 32'h1111_2222, 4'hF,
                2, 1, 1, 0, 0, 2, 2'b00, 32'h0, 1'b1);
        run_txn("b2b_second", 1'b0, 32'h0000_0504, 32'h0, 4'h0,
                0, 0, 0, 1, 2, 0, 2'b01, 32'h3333_4444, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        last_we = 1'b0; last_data = '0; last_code = '0;
        miso = '0;
        req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_wstrb = '0;
        resp_yumi = 1'b0;

        test_reset();
        test_zero_wait_write();
        test_skewed_write();
        test_read();
        test_error_backpressure();
        test_stray_input();
        test_reset_mid_op();
        test_back_to_back();
        test_random();

        req_v = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bsg_fifos_to_axil.md
BSG_FIFOS_TO_AXIL -- requirements
Module: bsg_fifos_to_axil

Interface
REQ-001 SHALL have no parameters; address and data widths are fixed at 32 bits and wstrb at 4 bits.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state is sampled on the rising edge.
REQ-003 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port m_axil_bus_o, output, `bsg_axil_mosi_bus_width(1)` bits: packed AXI-Lite master signals (awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready), using the team axil bus struct.
REQ-005 SHALL have port m_axil_bus_i, input, `bsg_axil_miso_bus_width(1)` bits: packed AXI-Lite slave signals (awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid).
REQ-006 SHALL have the request ports:
- req_v_i, input, 1 bit
- req_we_i, input, 1 bit (1 = write, 0 = read)
- req_addr_i, input, 32 bits
- req_data_i, input, 32 bits
- req_wstrb_i, input, 4 bits
- req_ready_o, output, 1 bit
REQ-007 SHALL have the response ports:
- resp_v_o, output, 1 bit
- resp_we_o, output, 1 bit
- resp_data_o, output, 32 bits
- resp_code_o, output, 2 bits (bresp or rresp)
- resp_yumi_i, input, 1 bit
REQ-008 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-009 SHALL use a one-outstanding-transaction FSM with states IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA and RESP.
REQ-010 SHALL drive req_ready_o=1 only in IDLE with reset deasserted; a request is accepted when req_v_i & req_ready_o.
REQ-011 SHALL, on acceptance, register addr, data, wstrb and we, then move to WR_REQ (we=1) or RD_ADDR (we=0).
REQ-012 SHALL, in WR_REQ, assert awvalid and wvalid from the first cycle after acceptance, with awaddr, wdata and wstrb stable from the registered values.
REQ-013 SHALL track the aw and w handshakes with independent done flags: each valid drops the cycle after its own handshake; either order or the same cycle is legal; the state moves to WR_RESP once both flags are set.
REQ-014 SHALL hold bready=1 only in WR_RESP; bvalid outside WR_RESP SHALL be ignored; on bvalid & bready, capture bresp, set resp_data_o=0 and move to RESP.
REQ-015 SHALL hold arvalid=1 in RD_ADDR until arready, then move to RD_DATA.
REQ-016 SHALL hold rready=1 only in RD_DATA; on rvalid, capture rdata and rresp and move to RESP.
REQ-017 SHALL hold resp_v_o=1 in RESP with resp_we_o, resp_data_o and resp_code_o stable until resp_yumi_i; on resp_yumi_i return to IDLE.
REQ-018 SHALL ignore resp_yumi_i while resp_v_o=0.
REQ-019 SHALL forward nonzero bresp/rresp (SLVERR/DECERR) unchanged; error codes do not alter the FSM.
REQ-020 SHALL meet minimum latency with a zero-wait slave: acceptance at cycle 0, aw/w handshake at cycle 1, b handshake at cycle 2, resp_v_o at cycle 3; a read has the same cycle positions.
REQ-021 SHALL keep req_ready_o=0 while busy, so back-to-back requests are serialized.
REQ-022 SHALL not combinationally depend the AXI valids on any AXI ready input.

Reset
REQ-023 SHALL, on reset_n_i=0, immediately (asynchronously) drive state to IDLE, all AXI valids and readies to 0, resp_v_o=0, busy_o=0 and req_ready_o=0.
REQ-024 SHALL clear the captured data, code and we registers to 0 on reset.
REQ-025 SHALL, on reset mid-transaction, drop the in-flight transaction and any pending response without emitting them.
REQ-026 SHALL begin accepting requests the first clock edge after reset_n_i rises.

Verification
REQ-027 SHALL pass a zero-wait write: req addr=0x10C, data=0xA5A5_0001, wstrb=0xF -> awaddr=0x10C and wdata=0xA5A5_0001 at cycle 1; resp_v_o at cycle 3 with resp_we_o=1, code=0, data=0.
REQ-028 SHALL pass a skewed write: wready 3 cycles before awready -> wvalid drops after its handshake, awvalid is held, bready asserts only after both handshakes, one response is produced.
REQ-029 SHALL pass a read: req addr=0x11C with arready 2 cycles late and rdata=0x0000_0004 -> resp_data_o=0x4, resp_we_o=0, code=0.
REQ-030 SHALL pass error and backpressure: rresp=2'b10 with resp_yumi_i held low 5 cycles -> resp_v_o and resp_code_o=2 stay stable, req_ready_o=0 throughout, IDLE after the yumi.
REQ-031 SHALL pass reset mid-operation: reset_n_i low while in WR_RESP -> all valids are 0 in the same cycle, no response appears, and the next request works normally.
REQ-032 SHALL pass stray input: bvalid=1 asserted while in IDLE -> no response and no state change.
